// File: rtl/ibus_dbus_arbiter_pkg.sv
// Shared defines for the IF/MEM bus arbiter: state encodings, stall-controller
// constants and default bus widths.
package ibus_dbus_arbiter_pkg;

  localparam int unsigned BusAddrW     = 32;
  localparam int unsigned BusDataW     = 32;
  localparam int unsigned MaxMemStreak = 4;

  // Stall-controller encodings shared with the rest of the pipeline
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic RstEnable = 1'b1;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbBusyIf  = 2'd1,
    ArbBusyMem = 2'd2,
    ArbDrain   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ibus_dbus_arbiter.sv
// Arbitrates the single Wishbone-style memory bus between instruction fetch and
// data access; MEM has priority, bounded by a streak limit so fetch cannot starve.
module ibus_dbus_arbiter
  import ibus_dbus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = BusAddrW,
  parameter int unsigned DATA_W         = BusDataW,
  parameter int unsigned MAX_MEM_STREAK = MaxMemStreak
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  output logic                stallreq_if,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_sel,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  output logic                stallreq_mem,
  output logic                bus_cyc,
  output logic                bus_stb,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack
);

  localparam int unsigned SelW    = DATA_W / 8;
  localparam int unsigned StreakW = $clog2(MAX_MEM_STREAK + 1);

  arb_state_e         state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;

  logic              bus_cyc_d, bus_stb_d, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [SelW-1:0]   bus_sel_d;
  logic [DATA_W-1:0] bus_wdata_d;
  logic              if_ack_d, mem_ack_d;
  logic [DATA_W-1:0] if_rdata_d, mem_rdata_d;

  logic if_eligible;
  logic streak_full;

  assign if_eligible = if_req & ~flush;
  assign streak_full = (streak_q >= StreakW'(MAX_MEM_STREAK));

  // Stall requests follow the requester directly; forced to NoStop in reset
  assign stallreq_if  = (rst == RstEnable) ? NoStop : ((if_req  & ~if_ack)  ? Stop : NoStop);
  assign stallreq_mem = (rst == RstEnable) ? NoStop : ((mem_req & ~mem_ack) ? Stop : NoStop);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= ArbIdle;
      streak_q  <= '0;
      bus_cyc   <= 1'b0;
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      bus_cyc   <= bus_cyc_d;
      bus_stb   <= bus_stb_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_sel   <= bus_sel_d;
      bus_wdata <= bus_wdata_d;
      if_ack    <= if_ack_d;
      mem_ack   <= mem_ack_d;
      if_rdata  <= if_rdata_d;
      mem_rdata <= mem_rdata_d;
    end
  end

  // Next-state, arbitration and output values
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    bus_cyc_d   = bus_cyc;
    bus_stb_d   = bus_stb;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_sel_d   = bus_sel;
    bus_wdata_d = bus_wdata;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata;
    mem_rdata_d = mem_rdata;

    case (state_q)
      ArbIdle: begin
        // The ack cycle still shows the finished request, so nothing is granted then
        if (!(if_ack || mem_ack)) begin
          if (mem_req && !(if_eligible && streak_full)) begin
            state_d     = ArbBusyMem;
            streak_d    = if_eligible ? (streak_q + StreakW'(1)) : '0;
            bus_cyc_d   = 1'b1;
            bus_stb_d   = 1'b1;
            bus_we_d    = mem_we;
            bus_addr_d  = mem_addr;
            bus_sel_d   = mem_sel;
            bus_wdata_d = mem_wdata;
          end else if (if_eligible) begin
            state_d     = ArbBusyIf;
            streak_d    = '0;
            bus_cyc_d   = 1'b1;
            bus_stb_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_addr_d  = if_addr;
            bus_sel_d   = '1;
            bus_wdata_d = '0;
          end
        end
      end
      ArbBusyIf: begin
        if (bus_ack) begin
          state_d   = ArbIdle;
          bus_cyc_d = 1'b0;
          bus_stb_d = 1'b0;
          if (!flush) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_rdata;
          end
        end else if (flush) begin
          state_d = ArbDrain;
        end
      end
      ArbBusyMem: begin
        if (bus_ack) begin
          state_d     = ArbIdle;
          bus_cyc_d   = 1'b0;
          bus_stb_d   = 1'b0;
          mem_ack_d   = 1'b1;
          mem_rdata_d = bus_rdata;
        end
      end
      ArbDrain: begin
        // Flushed fetch still owns the bus; its data is dropped
        if (bus_ack) begin
          state_d   = ArbIdle;
          bus_cyc_d = 1'b0;
          bus_stb_d = 1'b0;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

endmodule
